// File: rtl/store_narrower_if.sv
// Store request/response bundle for the store narrowing stage.
// The upstream side presents a register value plus access info; the
// downstream side sees the lane-aligned store with byte enables.
interface store_narrower_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  in_size;
  logic [2:0]  in_addr;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_be;
  logic        out_lost;
  logic        out_misaligned;

  // Driver of requests and consumer of narrowed stores (pipeline neighbours).
  modport master (
    output in_valid, in_data, in_size, in_addr, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_be, out_lost, out_misaligned
  );

  // The narrowing stage itself.
  modport slave (
    input  in_valid, in_data, in_size, in_addr, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_be, out_lost, out_misaligned
  );
endinterface

// File: rtl/store_narrower.sv
// Store-data narrowing stage: truncates a 64-bit register value to the
// access size, shifts it into the addressed byte lanes with byte enables,
// flags information lost by truncation and misaligned accesses. Registered
// output with a one-entry skid buffer so back-pressure never drops a store.
module store_narrower (
  input  logic            clk,
  input  logic            reset,
  store_narrower_if.slave bus
);

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  be;
    logic        lost;
    logic        misaligned;
  } entry_t;

  logic [63:0] field_mask;
  logic [7:0]  be_base;
  logic [2:0]  size_mask;
  logic        sign_bit;
  logic [63:0] ext_pattern;
  entry_t      narrowed;

  entry_t      m_q;
  logic        m_valid;
  entry_t      s_q;
  logic        s_valid;

  logic        accept;
  logic        drain;
  logic        m_free;

  // Decode the access size into a field mask, base byte enables,
  // alignment mask and the sign bit of the narrowed field.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    field_mask = '1;
    be_base    = 8'hFF;
    size_mask  = 3'b111;
    sign_bit   = bus.in_data[63];
    case (bus.in_size)
      2'd0: begin
        field_mask = 64'h0000_0000_0000_00FF;
        be_base    = 8'h01;
        size_mask  = 3'b000;
        sign_bit   = bus.in_data[7];
      end
      2'd1: begin
        field_mask = 64'h0000_0000_0000_FFFF;
        be_base    = 8'h03;
        size_mask  = 3'b001;
        sign_bit   = bus.in_data[15];
      end
      2'd2: begin
        field_mask = 64'h0000_0000_FFFF_FFFF;
        be_base    = 8'h0F;
        size_mask  = 3'b011;
        sign_bit   = bus.in_data[31];
      end
      default: begin
        field_mask = '1;
        be_base    = 8'hFF;
        size_mask  = 3'b111;
        sign_bit   = bus.in_data[63];
      end
    endcase
  end

  // Build the narrowed entry; bits above the field must match the extension
  // pattern, so a double (full mask) can never report loss.
  always_comb begin
    narrowed            = '0;
    ext_pattern         = {64{bus.in_signed & sign_bit}};
    narrowed.lost       = |((bus.in_data ^ ext_pattern) & ~field_mask);
    narrowed.misaligned = |(bus.in_addr & size_mask);
    if (!narrowed.misaligned) begin
      narrowed.data = (bus.in_data & field_mask) << {bus.in_addr, 3'b000};
      narrowed.be   = be_base << bus.in_addr;
    end
  end

  // in_ready depends only on registered skid state, never on out_ready.
  assign accept = bus.in_valid && !s_valid;
  assign drain  = m_valid && bus.out_ready;
  assign m_free = !m_valid || drain;

  // Main and skid registers; skid contents take priority into M to keep order.
  // NOTE: payload registers are reset too because out_data/out_be must read
  // zero during reset, not just the valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q     <= '0;
      m_valid <= 1'b0;
      s_q     <= '0;
      s_valid <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (m_free) begin
        if (s_valid) begin
          m_q     <= s_q;
          m_valid <= 1'b1;
          s_valid <= 1'b0;
        end else if (accept) begin
          m_q     <= narrowed;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (accept) begin
        s_q     <= narrowed;
        s_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready       = !s_valid;
  assign bus.out_valid      = m_valid;
  assign bus.out_data       = m_q.data;
  assign bus.out_be         = m_q.be;
  assign bus.out_lost       = m_q.lost;
  assign bus.out_misaligned = m_q.misaligned;

endmodule

// File: tb/tb_store_narrower.sv
// Self-checking bench for store_narrower: table of hand-derived vectors,
// randomized requests against a byte-lane model, and hand-written
// back-pressure, throughput and mid-operation reset sequences. A scoreboard
// queue holds expected stores in acceptance order.
module tb_store_narrower;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  be;
    logic        lost;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  sz;
    logic [2:0]  a;
    logic        sg;
    exp_t        e;
  } vec_t;

  logic clk;
  logic reset;
  store_narrower_if bus ();

  store_narrower dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   drains = 0;
  int   cyc    = 0;
  exp_t sb[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-lane reference model of the narrowing function.
  function automatic exp_t model(input logic [63:0] d, input logic [1:0] sz,
                                 input logic [2:0] a, input logic sg);
    exp_t e;
    int   n;
    logic ext;
    e   = '0;
    n   = 1 << sz;
    ext = sg ? d[8*n-1] : 1'b0;
    for (int i = 8 * n; i < 64; i++)
      if (d[i] !== ext) e.lost = 1'b1;
    if ((int'(a) % n) != 0) e.mis = 1'b1;
    else begin
      for (int k = 0; k < n; k++) begin
        e.be[int'(a) + k]               = 1'b1;
        e.data[8*(int'(a) + k) +: 8]    = d[8*k +: 8];
      end
    end
    return e;
  endfunction

  // Output monitor: every valid cycle must match the scoreboard head
  // (which also proves stability while stalled); pop on a drain.
  always @(negedge clk) begin
    cyc++;
    if (reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        check("out_data", bus.out_data, sb[0].data);
        check("out_be", {56'd0, bus.out_be}, {56'd0, sb[0].be});
        check("out_lost", {63'd0, bus.out_lost}, {63'd0, sb[0].lost});
        check("out_misaligned", {63'd0, bus.out_misaligned}, {63'd0, sb[0].mis});
        if (bus.out_ready) begin
          void'(sb.pop_front());
          drains++;
        end
      end
    end
  end

  // Present a request, hold it until accepted, then record the expectation.
  // Leaves in_valid high so calls can be chained back to back.
  task automatic send(input logic [63:0] d, input logic [1:0] sz, input logic [2:0] a,
                      input logic sg, input exp_t e, input bit rand_ready);
    logic taken;
    taken         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_size   = sz;
    bus.in_addr   = a;
    bus.in_signed = sg;
    for (int t = 0; t < 50 && !taken; t++) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      taken = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (taken) sb.push_back(e);
    else check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    logic [63:0] rd;
    logic [1:0]  rsz;
    logic [2:0]  ra;
    logic        rsg;
    int          d0;
    int          c0;

    vecs[0]  = '{64'h0000_0000_0000_00AB, 2'd0, 3'd5, 1'b0, '{64'h0000_AB00_0000_0000, 8'h20, 1'b0, 1'b0}};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FCB1, 2'd1, 3'd2, 1'b1, '{64'h0000_0000_FCB1_0000, 8'h0C, 1'b0, 1'b0}};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FCB1, 2'd1, 3'd2, 1'b0, '{64'h0000_0000_FCB1_0000, 8'h0C, 1'b1, 1'b0}};
    vecs[3]  = '{64'h0000_0000_1234_5678, 2'd2, 3'd2, 1'b0, '{64'h0,                  8'h00, 1'b0, 1'b1}};
    vecs[4]  = '{64'h0000_0000_0000_0001, 2'd3, 3'd0, 1'b0, '{64'h0000_0000_0000_0001, 8'hFF, 1'b0, 1'b0}};
    vecs[5]  = '{64'h0000_0000_0000_0180, 2'd0, 3'd0, 1'b0, '{64'h0000_0000_0000_0080, 8'h01, 1'b1, 1'b0}};
    vecs[6]  = '{64'hFFFF_FFFF_FFFF_FF80, 2'd0, 3'd7, 1'b1, '{64'h8000_0000_0000_0000, 8'h80, 1'b0, 1'b0}};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FF7F, 2'd0, 3'd3, 1'b1, '{64'h0000_0000_7F00_0000, 8'h08, 1'b1, 1'b0}};
    vecs[8]  = '{64'hDEAD_BEEF_CAFE_F00D, 2'd2, 3'd4, 1'b0, '{64'hCAFE_F00D_0000_0000, 8'hF0, 1'b1, 1'b0}};
    vecs[9]  = '{64'h0000_0000_0000_1234, 2'd1, 3'd1, 1'b0, '{64'h0,                  8'h00, 1'b0, 1'b1}};
    vecs[10] = '{64'h8000_0000_0000_0000, 2'd3, 3'd3, 1'b1, '{64'h0,                  8'h00, 1'b0, 1'b1}};
    vecs[11] = '{64'hFFFF_FFFF_8000_0000, 2'd2, 3'd0, 1'b1, '{64'h0000_0000_8000_0000, 8'h0F, 1'b0, 1'b0}};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_size   = '0;
    bus.in_addr   = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;
    reset         = 1'b0;
    #2;
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_out_data", bus.out_data, 64'd0);
    check("reset_out_be", {56'd0, bus.out_be}, 64'd0);
    check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, one idle cycle apart, then back to back.
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].sz, vecs[i].a, vecs[i].sg, vecs[i].e, 1'b0);
      idle(1);
    end
    foreach (vecs[i]) send(vecs[i].d, vecs[i].sz, vecs[i].a, vecs[i].sg, vecs[i].e, 1'b0);
    idle(3);
    check("table_drained", 64'(sb.size()), 64'd0);

    // Back-pressure: A lands in M, B in the skid; in_ready falls.
    bus.out_ready = 1'b0;
    send(64'h1, 2'd3, 3'd0, 1'b0, model(64'h1, 2'd3, 3'd0, 1'b0), 1'b0);
    send(64'h2, 2'd3, 3'd0, 1'b0, model(64'h2, 2'd3, 3'd0, 1'b0), 1'b0);
    bus.in_valid = 1'b0;
    check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    idle(3);
    check("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
    check("bp_hold_a", bus.out_data, 64'h1);
    d0 = drains;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_back", {63'd0, bus.in_ready}, 64'd1);
    check("bp_b_in_m", bus.out_data, 64'h2);
    @(posedge clk);
    #1;
    check("bp_consecutive", 64'(drains - d0), 64'd2);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Full throughput: 8 back-to-back doubles drain in 8 consecutive cycles.
    d0 = drains;
    for (int i = 0; i < 8; i++) begin
      rd = {$urandom, $urandom};
      send(rd, 2'd3, 3'd0, 1'b0, model(rd, 2'd3, 3'd0, 1'b0), 1'b0);
    end
    c0 = cyc;
    bus.in_valid = 1'b0;
    check("thru_cycles", 64'(c0 - cyc + (drains - d0)), 64'd7);
    idle(2);
    check("thru_count", 64'(drains - d0), 64'd8);

    // Random requests with random back-pressure.
    for (int i = 0; i < 60; i++) begin
      rd  = {$urandom, $urandom};
      if (i % 3 == 0) rd = {{56{rd[7]}}, rd[7:0]};
      rsz = 2'($urandom_range(0, 3));
      ra  = 3'($urandom_range(0, 7));
      rsg = 1'($urandom_range(0, 1));
      send(rd, rsz, ra, rsg, model(rd, rsz, ra, rsg), 1'b1);
      if (i % 5 == 0) idle(1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    check("rand_drained", 64'(sb.size()), 64'd0);

    // Mid-operation reset with M and S both full.
    bus.out_ready = 1'b0;
    send(64'hAAAA, 2'd3, 3'd0, 1'b0, model(64'hAAAA, 2'd3, 3'd0, 1'b0), 1'b0);
    send(64'hBBBB, 2'd3, 3'd0, 1'b0, model(64'hBBBB, 2'd3, 3'd0, 1'b0), 1'b0);
    bus.in_valid = 1'b0;
    check("rst_pre_full", {63'd0, bus.in_ready}, 64'd0);
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_be", {56'd0, bus.out_be}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    sb.delete();
    d0 = drains;
    #4 reset = 1'b1;
    bus.out_ready = 1'b1;
    idle(5);
    check("rst_nothing_emitted", 64'(drains - d0), 64'd0);
    check("rst_out_valid_after", {63'd0, bus.out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
